// File: rtl/add_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_share_pkg
// Description : Shared definitions for the shared-adder controller. Holds the
//               FSM state encoding, requester id constants and the width of
//               the settle counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package add_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;
    localparam int   SETTLE_W = 4;

endpackage
`default_nettype wire

// File: rtl/add_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant. A lone requester always wins; when
//               both request, the pointer names the winner.
// Ports       : i_req    - request bits, one per requester
//               i_ptr    - requester id favoured on contention
//               o_grant  - one-hot grant (all zero when nobody requests)
//               o_winner - id of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import add_share_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_winner
);

    always_comb begin
        o_winner = REQ0;
        o_grant  = 2'b00;
        if (i_req == 2'b11) begin
            o_winner = i_ptr;
        end else if (i_req[1]) begin
            o_winner = REQ1;
        end
        if (i_req != 2'b00) begin
            o_grant = (o_winner == REQ1) ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : add_share_ctrl
// Description : Shares one slow combinational WIDTH-bit adder between two
//               requesters. Round-robin arbitration in IDLE, registered
//               operands are held for SETTLE_CYCLES cycles, then the adder
//               output is captured and returned over a valid/ready handshake.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               REQn_VALID/READY/A/B - operand request from requester n
//               RSPn_VALID/READY/SUM - result return to requester n
//               RSPn_OVF             - signed overflow of the returned sum
//                                      (only with ADD_SHARE_CTRL_OVF_EN)
//               ADD_A, ADD_B, ADD_SUM - interface to the shared adder
//               BUSY                 - high whenever the FSM is not in IDLE
// Options     : define ADD_SHARE_CTRL_OVF_EN to build the overflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module add_share_ctrl
    import add_share_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 4
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic [WIDTH-1:0] RSP0_SUM,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [WIDTH-1:0] RSP1_SUM,
    output logic [WIDTH-1:0] ADD_A,
    output logic [WIDTH-1:0] ADD_B,
    input  logic [WIDTH-1:0] ADD_SUM,
`ifdef ADD_SHARE_CTRL_OVF_EN
    output logic             RSP0_OVF,
    output logic             RSP1_OVF,
`endif
    output logic             BUSY
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("add_share_ctrl: SETTLE_CYCLES must lie in 1..15");
        end
    endgenerate

    localparam logic [SETTLE_W-1:0] c_cnt_load = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ptr;
    logic                r_owner;
    logic [SETTLE_W-1:0] r_cnt;
    logic [WIDTH-1:0]    r_add_a;
    logic [WIDTH-1:0]    r_add_b;
    logic [WIDTH-1:0]    r_sum0;
    logic [WIDTH-1:0]    r_sum1;
    logic [1:0]          w_grant;
    logic                w_winner;
    logic                w_accept;
    logic                w_rsp_ready;

    rr_arb2 u_arb (
        .i_req    ({REQ1_VALID, REQ0_VALID}),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    assign w_rsp_ready = (r_owner == REQ1) ? RSP1_READY : RSP0_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // READY is masked while RST is high so no handshake is reported in a
    // cycle whose edge is going to discard it.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        REQ0_READY  = 1'b0;
        REQ1_READY  = 1'b0;
        RSP0_VALID  = 1'b0;
        RSP1_VALID  = 1'b0;
        BUSY        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                REQ0_READY = w_grant[0] & ~RST;
                REQ1_READY = w_grant[1] & ~RST;
                if ((w_grant != 2'b00) && !RST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                RSP0_VALID = (r_owner == REQ0);
                RSP1_VALID = (r_owner == REQ1);
                if (w_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr   <= REQ0;
            r_owner <= REQ0;
            r_cnt   <= '0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_sum0  <= '0;
            r_sum1  <= '0;
        end else begin
            if (w_accept) begin
                r_add_a <= (w_winner == REQ1) ? REQ1_A : REQ0_A;
                r_add_b <= (w_winner == REQ1) ? REQ1_B : REQ0_B;
                r_owner <= w_winner;
                r_cnt   <= c_cnt_load;
            end
            if (r_state == SETTLE) begin
                if (r_cnt == '0) begin
                    if (r_owner == REQ1) begin
                        r_sum1 <= ADD_SUM;
                    end else begin
                        r_sum0 <= ADD_SUM;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            if ((r_state == RESP) && w_rsp_ready) begin
                r_ptr <= ~r_owner;
            end
        end
    end

`ifdef ADD_SHARE_CTRL_OVF_EN
    logic r_ovf0;
    logic r_ovf1;
    logic w_ovf;

    // Signed overflow: operands agree in sign and the sum does not.
    assign w_ovf = (r_add_a[WIDTH-1] == r_add_b[WIDTH-1]) &&
                   (ADD_SUM[WIDTH-1] != r_add_a[WIDTH-1]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf0 <= 1'b0;
            r_ovf1 <= 1'b0;
        end else if ((r_state == SETTLE) && (r_cnt == '0)) begin
            if (r_owner == REQ1) begin
                r_ovf1 <= w_ovf;
            end else begin
                r_ovf0 <= w_ovf;
            end
        end
    end

    assign RSP0_OVF = r_ovf0;
    assign RSP1_OVF = r_ovf1;
`endif

    assign ADD_A    = r_add_a;
    assign ADD_B    = r_add_b;
    assign RSP0_SUM = r_sum0;
    assign RSP1_SUM = r_sum1;

endmodule
`default_nettype wire
